// File: rtl/snake_game_ctrl.sv
// Snake game-state sequencer: segment store, tick-driven stepping, collision and growth,
// plus a registered tile classifier for the VGA scan position.
module snake_game_ctrl #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [5:0] apple_x,
  input  logic [4:0] apple_y,
  output logic [1:0] snake,
  output logic       apple_eaten,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;
  typedef enum logic [1:0] {D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11} dir_t;

  function automatic dir_t rev(input dir_t d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      default: return D_LEFT;
    endcase
  endfunction

  state_t        state, state_nx;
  dir_t          cur_dir, pend_dir, dir_in, eff_dir;
  logic [TW-1:0] tick_cnt;
  logic [LW-1:0] len;
  logic [5:0]    seg_x [MAX_LEN];
  logic [4:0]    seg_y [MAX_LEN];
  logic [5:0]    nh_x;
  logic [4:0]    nh_y;
  logic          step, grow, hit_wall, hit_body, collide, reinit;
  logic [5:0]    tx;
  logic [4:0]    ty;
  logic          visible, on_wall, on_head, on_body;
  logic [1:0]    code;

  always_comb begin
    dir_in  = dir_t'(dir_req);
    step    = (state == S_PLAY) && (tick_cnt == TICK_LAST);
    reinit  = (state == S_DEAD) && start;
    // A request landing on the step cycle is judged against the direction just adopted.
    eff_dir = step ? pend_dir : cur_dir;
  end

  always_comb begin
    nh_x = seg_x[0];
    nh_y = seg_y[0];
    unique case (pend_dir)
      D_UP:    nh_y = seg_y[0] - 5'd1;
      D_DOWN:  nh_y = seg_y[0] + 5'd1;
      D_LEFT:  nh_x = seg_x[0] - 6'd1;
      D_RIGHT: nh_x = seg_x[0] + 6'd1;
    endcase
    grow     = (nh_x == apple_x) && (nh_y == apple_y);
    hit_wall = (nh_x == 6'd0) || (nh_x == 6'd39) || (nh_y == 5'd0) || (nh_y == 5'd29);
    hit_body = 1'b0;
    // The tail vacates its tile on a plain move, so it only blocks when the snake grows.
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((i + 1 < 32'(len)) || (grow && (i < 32'(len)))) begin
        if ((seg_x[i] == nh_x) && (seg_y[i] == nh_y)) hit_body = 1'b1;
      end
    end
    collide = hit_wall || hit_body;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_PLAY;
      S_PLAY: if (step && collide) state_nx = S_DEAD;
      S_DEAD: if (start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst || reinit) begin
      tick_cnt    <= '0;
      len         <= LW'(INIT_LEN);
      cur_dir     <= D_RIGHT;
      pend_dir    <= D_RIGHT;
      apple_eaten <= 1'b0;
      score       <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(20 - i);
        seg_y[i] <= 5'd15;
      end
    end else begin
      apple_eaten <= 1'b0;
      if ((state != S_PLAY) || step) tick_cnt <= '0;
      else                           tick_cnt <= tick_cnt + TW'(1);
      if (step) begin
        cur_dir <= pend_dir;
        if (!collide) begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nh_x;
          seg_y[0] <= nh_y;
          if (grow) begin
            apple_eaten <= 1'b1;
            if (len != LW'(MAX_LEN)) len <= len + LW'(1);
            if (score != 8'hFF) score <= score + 8'd1;
          end
        end
      end
      if (dir_valid && (dir_in != rev(eff_dir))) pend_dir <= dir_in;
    end
  end

  always_comb begin
    tx      = x_pos[9:4];
    ty      = y_pos[8:4];
    visible = (x_pos < 10'd640) && (y_pos < 10'd480);
    on_wall = (tx == 6'd0) || (tx == 6'd39) || (ty == 5'd0) || (ty == 5'd29);
    on_head = (seg_x[0] == tx) && (seg_y[0] == ty);
    on_body = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if ((i < 32'(len)) && (seg_x[i] == tx) && (seg_y[i] == ty)) on_body = 1'b1;
    end
    code = 2'b00;
    if (visible) begin
      if (on_wall)      code = 2'b11;
      else if (on_head) code = 2'b01;
      else if (on_body) code = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) snake <= 2'b00;
    else     snake <= code;
  end

  always_comb game_over = (state == S_DEAD);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed and randomized checks of snake_game_ctrl against a queue-based game model.
module tb_snake_game_ctrl;

  localparam int MAXL  = 8;
  localparam int INITL = 3;
  localparam int TD    = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_DEAD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, dir_valid = 1'b0;
  logic [1:0] dir_req = 2'b00;
  logic [9:0] x_pos = 10'd320, y_pos = 10'd240;
  logic [5:0] apple_x = 6'd5;
  logic [4:0] apple_y = 5'd5;
  logic [1:0] snake;
  logic       apple_eaten, game_over;
  logic [7:0] score;

  always #5 clk = ~clk;

  snake_game_ctrl #(.MAX_LEN(MAXL), .INIT_LEN(INITL), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .dir_valid(dir_valid), .dir_req(dir_req),
    .x_pos(x_pos), .y_pos(y_pos), .apple_x(apple_x), .apple_y(apple_y),
    .snake(snake), .apple_eaten(apple_eaten), .game_over(game_over), .score(score)
  );

  typedef struct {int x; int y;} pt_t;
  pt_t        q[$];
  int         mst, mtick, mcur, mpend, mscore;
  logic [1:0] exp_snake;
  logic       exp_eaten;
  int         total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void minit();
    q.delete();
    for (int i = 0; i < INITL; i++) q.push_back('{20 - i, 15});
    mst = M_IDLE; mtick = 0; mcur = 3; mpend = 3; mscore = 0;
  endfunction

  function automatic logic [1:0] mlook(input int px, input int py);
    int tx, ty;
    if (px >= 640 || py >= 480) return 2'b00;
    tx = px / 16; ty = py / 16;
    if (tx == 0 || tx == 39 || ty == 0 || ty == 29) return 2'b11;
    if (q[0].x == tx && q[0].y == ty) return 2'b01;
    for (int k = 1; k < q.size(); k++)
      if (q[k].x == tx && q[k].y == ty) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void mstep();
    int nx, ny, lim;
    bit grow, hit;
    nx = q[0].x; ny = q[0].y;
    case (mpend)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
    grow = (nx == int'(apple_x)) && (ny == int'(apple_y));
    hit  = (nx == 0 || nx == 39 || ny == 0 || ny == 29);
    lim  = grow ? q.size() : q.size() - 1;
    for (int k = 0; k < lim; k++)
      if (q[k].x == nx && q[k].y == ny) hit = 1;
    if (hit) mst = M_DEAD;
    else begin
      q.push_front('{nx, ny});
      if (!grow || q.size() > MAXL) void'(q.pop_back());
      if (grow) begin
        exp_eaten = 1'b1;
        if (mscore < 255) mscore++;
      end
    end
    mcur = mpend;
  endfunction

  // Computes the state the DUT must hold after the coming clock edge.
  function automatic void model_clock();
    bit stp, was_play;
    int eff;
    exp_eaten = 1'b0;
    if (rst) begin
      minit();
      exp_snake = 2'b00;
      return;
    end
    exp_snake = mlook(int'(x_pos), int'(y_pos));
    if (mst == M_DEAD && start) begin
      minit();
      return;
    end
    was_play = (mst == M_PLAY);
    stp = was_play && (mtick == TD - 1);
    eff = stp ? mpend : mcur;
    if (stp) mstep();
    mtick = (was_play && !stp) ? mtick + 1 : 0;
    if (dir_valid && (int'(dir_req) != (eff ^ 1))) mpend = int'(dir_req);
    if (!was_play && mst == M_IDLE && start) mst = M_PLAY;
  endfunction

  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
    chk("snake", snake, exp_snake);
    chk("apple_eaten", apple_eaten, exp_eaten);
    chk("game_over", game_over, (mst == M_DEAD));
    chk("score", score, mscore);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic probe_tile(input int tx, input int ty);
    x_pos = 10'(tx * 16 + 3);
    y_pos = 10'(ty * 16 + 7);
  endtask

  task automatic random_probe();
    int r, k;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      x_pos = 10'($urandom_range(600, 1023));
      y_pos = 10'($urandom_range(440, 1023));
    end else if (r <= 5) begin
      k = $urandom_range(0, q.size() - 1);
      x_pos = 10'(q[k].x * 16 + $urandom_range(0, 15));
      y_pos = 10'(q[k].y * 16 + $urandom_range(0, 15));
    end else begin
      x_pos = 10'($urandom_range(0, 639));
      y_pos = 10'($urandom_range(0, 479));
    end
  endtask

  task automatic apple_ahead();
    int ax, ay;
    ax = q[0].x; ay = q[0].y;
    case (mpend)
      0: ay = ay - 1;
      1: ay = ay + 1;
      2: ax = ax - 1;
      default: ax = ax + 1;
    endcase
    apple_x = 6'(ax);
    apple_y = 5'(ay);
  endtask

  initial begin
    minit();
    // Reset and idle lookup
    rst = 1'b1;
    run(2);
    chk("t1_score", score, 0);
    chk("t1_game_over", game_over, 0);
    chk("t1_snake_rst", snake, 2'b00);
    rst = 1'b0;
    cyc();
    chk("t1_head", snake, 2'b01);

    // Four steps straight right
    start = 1'b1; cyc(); start = 1'b0;
    run(16);
    probe_tile(24, 15); cyc(); chk("t2_head", snake, 2'b01);
    probe_tile(21, 15); cyc(); chk("t2_gone", snake, 2'b00);
    probe_tile(22, 15); cyc(); chk("t2_tail", snake, 2'b10);

    // Reverse request dropped, perpendicular request taken
    run(1);
    dir_valid = 1'b1; dir_req = 2'b10; cyc();
    dir_req = 2'b00; cyc();
    dir_valid = 1'b0;
    run(2);
    probe_tile(25, 14); cyc(); chk("t3_turn_up", snake, 2'b01);

    // Growth on the first step
    rst = 1'b1; apple_x = 6'd21; apple_y = 5'd15; cyc(); rst = 1'b0;
    x_pos = 10'd320; y_pos = 10'd240;
    start = 1'b1; cyc(); start = 1'b0;
    run(3);
    cyc();
    chk("t4_pulse", apple_eaten, 1);
    chk("t4_score", score, 1);
    cyc();
    chk("t4_pulse_end", apple_eaten, 0);
    probe_tile(18, 15); cyc(); chk("t4_len4", snake, 2'b10);
    probe_tile(17, 15); cyc(); chk("t4_beyond", snake, 2'b00);

    // Wall death, then restart clears score
    rst = 1'b1; apple_x = 6'd25; apple_y = 5'd15; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 0; n < 200 && game_over !== 1'b1; n++) cyc();
    chk("t5_dead", game_over, 1);
    chk("t5_score", score, 1);
    probe_tile(38, 15); cyc(); chk("t5_head38", snake, 2'b01);
    probe_tile(39, 15); cyc(); chk("t5_wall", snake, 2'b11);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t5_idle_go", game_over, 0);
    chk("t5_idle_score", score, 0);
    probe_tile(20, 15); cyc(); chk("t5_reinit_head", snake, 2'b01);

    // Reset in the middle of a tick period
    rst = 1'b1; apple_x = 6'd21; apple_y = 5'd15; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    run(2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_no_eat", apple_eaten, 0);
    chk("t6_go", game_over, 0);
    run(6);
    chk("t6_head", snake, 2'b01);
    start = 1'b1; cyc(); start = 1'b0;
    run(3);
    cyc();
    chk("t6_first_step", apple_eaten, 1);

    // Randomized play
    for (int ep = 0; ep < 30; ep++) begin
      if ($urandom_range(0, 3) == 0) begin rst = 1'b1; cyc(); rst = 1'b0; end
      if (mst == M_DEAD) begin start = 1'b1; cyc(); start = 1'b0; end
      start = 1'b1; cyc(); start = 1'b0;
      for (int n = 0; n < 400 && mst != M_DEAD; n++) begin
        random_probe();
        if (mst == M_PLAY && mtick != TD - 1 && $urandom_range(0, 5) == 0) begin
          dir_valid = 1'b1;
          dir_req = 2'($urandom_range(0, 3));
        end
        if (mtick == 0 && $urandom_range(0, 2) == 0) apple_ahead();
        else if ($urandom_range(0, 19) == 0) begin
          apple_x = 6'($urandom_range(1, 38));
          apple_y = 5'($urandom_range(1, 28));
        end
        start = ($urandom_range(0, 9) == 0);
        cyc();
        dir_valid = 1'b0;
        start = 1'b0;
      end
      for (int n = 0; n < 3; n++) begin random_probe(); cyc(); end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
